// File: rtl/athena_side_ram_injector.sv
// Side-VRAM bus injector: forwards the core's own side-RAM bus and, on host request,
// slips one byte read or write into an idle bus slot before handing the bus back.
package athena_side_ram_pkg;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data_in;
        logic        nCS;
        logic        VRD;
        logic        nWE;
        logic        VDG;
        logic        VOE;
        logic [7:0]  data_out;
    } side_ram_t;

endpackage

module athena_side_ram_injector
    import athena_side_ram_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int IDLE_CYCLES = 2,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              reset,
    input  side_ram_t         mon_i,
    output side_ram_t         ram_o,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DRIVE,
        S_DONE
    } state_t;

    localparam logic [3:0] IDLE_LIM  = 4'(IDLE_CYCLES);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        idle_cnt_q, idle_cnt_d;
    logic [3:0]        hold_cnt_q, hold_cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;

    logic bus_idle;
    logic driving;

    assign bus_idle = mon_i.nCS & mon_i.VRD & mon_i.nWE;
    // A DRIVE cycle that sees the core touching the bus yields it in that same cycle.
    assign driving  = (state_q == S_DRIVE) && bus_idle;

    always_ff @(posedge i_clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idle_cnt_q <= '0;
            hold_cnt_q <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= 8'h00;
        end else begin
            state_q    <= state_d;
            idle_cnt_q <= idle_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        hold_cnt_d = hold_cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (host_req) begin
                    we_d       = host_we;
                    addr_d     = host_addr;
                    wdata_d    = host_wdata;
                    idle_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus_idle) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q + 4'd1 >= IDLE_LIM) begin
                    idle_cnt_d = '0;
                    hold_cnt_d = '0;
                    state_d    = S_DRIVE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
            end
            S_DRIVE: begin
                if (!bus_idle) begin
                    idle_cnt_d = '0;
                    hold_cnt_d = '0;
                    state_d    = S_WAIT;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    if (!we_q) begin
                        rdata_d = mon_i.data_out;
                    end
                    state_d = S_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        ram_o = mon_i;
        if (driving) begin
            ram_o.addr = 16'(addr_q);
            ram_o.nCS  = 1'b0;
            ram_o.VDG  = 1'b0;
            if (we_q) begin
                ram_o.nWE     = 1'b0;
                ram_o.VRD     = 1'b1;
                ram_o.VOE     = 1'b1;
                ram_o.data_in = wdata_q;
            end else begin
                ram_o.nWE = 1'b1;
                ram_o.VRD = 1'b0;
                ram_o.VOE = 1'b0;
            end
        end
    end

    assign host_ack   = (state_q == S_DONE);
    assign busy       = (state_q == S_WAIT) || (state_q == S_DRIVE);
    assign host_rdata = rdata_q;

endmodule

// File: tb/tb_athena_side_ram_injector.sv
// Directed bench for athena_side_ram_injector: a transaction-level model is checked every
// cycle, plus literal latency/field expectations for each scenario.
module tb_athena_side_ram_injector;
    import athena_side_ram_pkg::*;

    localparam int IDLE = 2;
    localparam int HOLD = 4;
    localparam int AW   = 11;

    logic            clk   = 1'b0;
    logic            reset = 1'b1;
    side_ram_t       monBase;
    side_ram_t       monIn;
    side_ram_t       ramOut;
    logic [7:0]      memData   = 8'h00;
    logic            hostReq   = 1'b0;
    logic            hostWe    = 1'b0;
    logic [AW-1:0]   hostAddr  = '0;
    logic [7:0]      hostWdata = 8'h00;
    logic [7:0]      hostRdata;
    logic            hostAck;
    logic            busy;

    int vectors     = 0;
    int miscompares = 0;

    bit            mPending  = 1'b0;
    bit            mAck      = 1'b0;
    bit            mWe       = 1'b0;
    int            mIdleRun  = 0;
    int            mDriveIdx = -1;
    logic [AW-1:0] mAddr     = '0;
    logic [7:0]    mWdata    = 8'h00;
    logic [7:0]    mRdata    = 8'h00;

    int        cycleNo   = 0;
    int        ackCnt    = 0;
    int        lastAckAt = 0;
    int        driveCnt  = 0;
    side_ram_t lastDrive = '0;

    always #5 clk = ~clk;

    always_comb begin
        monIn          = monBase;
        monIn.data_out = memData;
    end

    athena_side_ram_injector #(
        .ADDR_W(AW),
        .IDLE_CYCLES(IDLE),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .i_clk(clk),
        .reset(reset),
        .mon_i(monIn),
        .ram_o(ramOut),
        .host_req(hostReq),
        .host_we(hostWe),
        .host_addr(hostAddr),
        .host_wdata(hostWdata),
        .host_rdata(hostRdata),
        .host_ack(hostAck),
        .busy(busy)
    );

    function automatic bit isIdle(input side_ram_t b);
        return b.nCS && b.VRD && b.nWE;
    endfunction

    function automatic side_ram_t expectedBus();
        side_ram_t e;
        e = monIn;
        if (mDriveIdx >= 0 && isIdle(monIn)) begin
            e.addr = 16'(mAddr);
            e.nCS  = 1'b0;
            e.VDG  = 1'b0;
            if (mWe) begin
                e.nWE     = 1'b0;
                e.VRD     = 1'b1;
                e.VOE     = 1'b1;
                e.data_in = mWdata;
            end else begin
                e.nWE = 1'b1;
                e.VRD = 1'b0;
                e.VOE = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Side VRAM stand-in: returns 0x3C while 0x7FF is being read, else the core's own value.
    initial forever begin
        @(posedge clk);
        #2;
        if (ramOut.nCS == 1'b0 && ramOut.VRD == 1'b0 && ramOut.addr == 16'h07FF)
            memData = 8'h3C;
        else
            memData = monBase.data_out;
    end

    // Transaction model: a pending request waits for IDLE idle cycles, then occupies HOLD
    // clean cycles; any core activity during the hold restarts the wait.
    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            mPending  = 1'b0;
            mAck      = 1'b0;
            mIdleRun  = 0;
            mDriveIdx = -1;
            mRdata    = 8'h00;
        end else if (mAck) begin
            mAck = 1'b0;
        end else if (!mPending) begin
            if (hostReq) begin
                mPending  = 1'b1;
                mWe       = hostWe;
                mAddr     = hostAddr;
                mWdata    = hostWdata;
                mIdleRun  = 0;
                mDriveIdx = -1;
            end
        end else if (mDriveIdx < 0) begin
            mIdleRun = isIdle(monIn) ? mIdleRun + 1 : 0;
            if (mIdleRun == IDLE) begin
                mIdleRun  = 0;
                mDriveIdx = 0;
            end
        end else if (!isIdle(monIn)) begin
            mDriveIdx = -1;
            mIdleRun  = 0;
        end else if (mDriveIdx == HOLD - 1) begin
            if (!mWe) mRdata = monIn.data_out;
            mPending  = 1'b0;
            mAck      = 1'b1;
            mDriveIdx = -1;
        end else begin
            mDriveIdx++;
        end
    end

    initial forever begin
        @(negedge clk);
        cycleNo++;
        if (hostAck === 1'b1) begin
            ackCnt++;
            lastAckAt = cycleNo;
        end
        if (ramOut.nCS == 1'b0 && isIdle(monIn)) begin
            driveCnt++;
            lastDrive = ramOut;
        end
        checkOutput("cycle ram_o", 64'(ramOut), 64'(expectedBus()));
        checkOutput("cycle busy", 64'(busy), 64'(mPending));
        checkOutput("cycle host_ack", 64'(hostAck), 64'(mAck));
        checkOutput("cycle host_rdata", 64'(hostRdata), 64'(mRdata));
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit we, input logic [AW-1:0] addr, input logic [7:0] wdata,
                                 output int reqAt);
        hostWe    = we;
        hostAddr  = addr;
        hostWdata = wdata;
        hostReq   = 1'b1;
        reqAt     = cycleNo + 1;
    endtask

    task automatic waitAck(input string name, input int limit, input int reqAt, input int expLatency);
        int startAcks;
        int n;
        startAcks = ackCnt;
        n = 0;
        while (ackCnt == startAcks && n < limit) begin
            @(posedge clk);
            n++;
        end
        #1;
        hostReq = 1'b0;
        if (ackCnt == startAcks) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL %s ack timeout: no ack within %0d cycles", name, limit);
        end else begin
            checkOutput({name, " latency"}, 64'(lastAckAt - reqAt), 64'(expLatency));
        end
    endtask

    initial begin
        side_ram_t idleBus;
        logic [63:0] r;
        int reqAt;
        int d0;
        int a0;

        idleBus = '{addr: 16'h0000, data_in: 8'h00, nCS: 1'b1, VRD: 1'b1, nWE: 1'b1,
                    VDG: 1'b1, VOE: 1'b1, data_out: 8'h00};
        monBase = idleBus;
        tick(3);
        checkOutput("reset busy", 64'(busy), 64'(0));
        checkOutput("reset host_ack", 64'(hostAck), 64'(0));
        checkOutput("reset host_rdata", 64'(hostRdata), 64'(8'h00));
        checkOutput("reset ram_o passthrough", 64'(ramOut), 64'(monIn));
        reset = 1'b0;
        tick(2);

        $display("[TB] pass-through with random core bus");
        for (int i = 0; i < 30; i++) begin
            r = {$urandom, $urandom};
            monBase = r[$bits(side_ram_t)-1:0];
            tick(1);
        end
        checkOutput("passthrough drives", 64'(driveCnt), 64'(0));
        checkOutput("passthrough acks", 64'(ackCnt), 64'(0));
        monBase = idleBus;
        tick(2);

        $display("[TB] write 0xA5 to 0x123");
        d0 = driveCnt;
        a0 = ackCnt;
        applyStimulus(1'b1, 11'h123, 8'hA5, reqAt);
        tick(1);
        hostWe    = 1'b0;
        hostAddr  = 11'h7AA;
        hostWdata = 8'h11;
        waitAck("write", 50, reqAt, 7);
        checkOutput("write drive cycles", 64'(driveCnt - d0), 64'(4));
        checkOutput("write ack count", 64'(ackCnt - a0), 64'(1));
        checkOutput("write addr", 64'(lastDrive.addr), 64'(16'h0123));
        checkOutput("write data_in", 64'(lastDrive.data_in), 64'(8'hA5));
        checkOutput("write nWE", 64'(lastDrive.nWE), 64'(0));
        checkOutput("write VRD", 64'(lastDrive.VRD), 64'(1));
        checkOutput("write VOE", 64'(lastDrive.VOE), 64'(1));
        checkOutput("write VDG", 64'(lastDrive.VDG), 64'(0));
        tick(2);

        $display("[TB] read from 0x7FF");
        applyStimulus(1'b0, 11'h7FF, 8'h00, reqAt);
        waitAck("read", 50, reqAt, 7);
        checkOutput("read rdata", 64'(hostRdata), 64'(8'h3C));
        checkOutput("read VRD", 64'(lastDrive.VRD), 64'(0));
        checkOutput("read VOE", 64'(lastDrive.VOE), 64'(0));
        checkOutput("read nWE", 64'(lastDrive.nWE), 64'(1));
        checkOutput("read addr", 64'(lastDrive.addr), 64'(16'h07FF));
        tick(2);

        $display("[TB] core holds the bus for 20 cycles");
        d0 = driveCnt;
        applyStimulus(1'b1, 11'h456, 8'h5A, reqAt);
        monBase.nCS = 1'b0;
        tick(20);
        monBase.nCS = 1'b1;
        waitAck("busy core", 80, reqAt, 26);
        checkOutput("busy core drive cycles", 64'(driveCnt - d0), 64'(4));
        checkOutput("busy core rdata kept", 64'(hostRdata), 64'(8'h3C));
        tick(2);

        $display("[TB] collision in second drive cycle");
        d0 = driveCnt;
        a0 = ackCnt;
        applyStimulus(1'b1, 11'h321, 8'h99, reqAt);
        tick(4);
        monBase.nCS = 1'b0;
        tick(1);
        monBase.nCS = 1'b1;
        waitAck("collision", 50, reqAt, 11);
        checkOutput("collision drive cycles", 64'(driveCnt - d0), 64'(5));
        checkOutput("collision ack count", 64'(ackCnt - a0), 64'(1));
        tick(2);

        $display("[TB] reset during drive");
        a0 = ackCnt;
        applyStimulus(1'b0, 11'h0AA, 8'h00, reqAt);
        tick(4);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("reset-in-drive ram_o", 64'(ramOut), 64'(monIn));
        checkOutput("reset-in-drive nCS", 64'(ramOut.nCS), 64'(1));
        checkOutput("reset-in-drive busy", 64'(busy), 64'(0));
        checkOutput("reset-in-drive ack", 64'(hostAck), 64'(0));
        checkOutput("reset-in-drive rdata", 64'(hostRdata), 64'(8'h00));
        hostReq = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(6);
        checkOutput("no ack after reset", 64'(ackCnt - a0), 64'(0));
        checkOutput("idle after reset busy", 64'(busy), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
